branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Given the current fetch PC, it produces predict_taken and predict_target in the same cycle.
- predict_taken drives the select of the PC-source 1-bit mux; predict_target feeds that mux's taken input.
- The execute stage writes back resolved branch outcomes through the update port.

Parameters:
- PC_WIDTH, 32, width of all PC and target buses.
- INDEX_BITS, 6, log2 of entry count (default 64 entries).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- fetch_pc  input  PC_WIDTH  PC of the instruction being fetched.
- predict_hit  output  1  valid entry with matching tag exists for fetch_pc.
- predict_taken  output  1  predict_hit and counter MSB = 1.
- predict_target  output  PC_WIDTH  stored target on hit; 0 otherwise.
- update_valid  input  1  a branch resolved this cycle.
- update_pc  input  PC_WIDTH  PC of the resolved branch.
- update_taken  input  1  actual outcome.
- update_target  input  PC_WIDTH  actual target address.

Behaviour:
- Address split, same for fetch_pc and update_pc:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2].
  - pc[1:0] is ignored.
- Storage per entry: valid (1), tag, target (PC_WIDTH), ctr (2).
- Reset (asynchronous, while reset=1): every valid=0, every ctr=2'b01, every target=0, every tag=0. All outputs read 0 during and right after reset.
- Lookup is purely combinational from stored state (0-cycle latency).
  - hit = valid[idx] && tag[idx] == fetch tag.
  - predict_taken = hit && ctr[idx][1].
  - predict_target = hit ? target[idx] : 0.
- Update is committed on the rising clk edge when update_valid=1:
  - Hit, taken: ctr saturating increment (11 stays 11); target <= update_target.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate. valid<=1, tag<=update tag, target<=update_target, ctr<=2'b10. Any previous occupant is overwritten.
  - Miss, not taken: no state change.
- update_valid=0: no state change.
- Same index read and written in the same cycle: lookup returns the pre-edge contents (no bypass). The new value is visible from the next cycle.
- Aliasing: two PCs with the same index and different tags evict each other. No associativity.
- Reset asserted mid-update: reset wins and that cycle's update is discarded.
- No X propagation: outputs are defined for any fetch_pc after reset.
- The table may be implemented as flops or as distributed RAM with asynchronous read. Reset must clear valid bits regardless; clearing other fields is required in flop implementations.

Test Plan:
- Reset, then fetch_pc=0x0040_0010 -> predict_hit=0, predict_taken=0, predict_target=0.
- Update pc=0x0040_0010, taken=1, target=0x0040_0100; next cycle fetch same pc -> hit=1, taken=1 (ctr=10), target=0x0040_0100.
- From that state, two not-taken updates to the same pc:
  - After the first, ctr=01 -> taken=0, hit=1.
  - After the second, ctr=00; a further not-taken keeps 00.
  - Then 3 taken updates -> ctr 01, 10, 11; taken=1 after the second one.
- Alias and no-allocate:
  - Entry for 0x0040_0010, then taken update of 0x0041_0010 (same index, different tag) -> old pc now misses, new pc hits with ctr=10.
  - Not-taken update of an unseen pc -> still misses.
- Same-cycle read/write: fetch_pc = update_pc = 0x0040_0020 with a taken allocate -> predict_hit=0 in that cycle, 1 in the next.
- Assert reset asynchronously between clock edges after several allocations -> outputs drop to 0 immediately. The update pending at that edge is lost, and all entries miss after release.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Lookup is a same-cycle combinational read of the table. Resolved branches from
// execute update the table on the rising clock edge.
module branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                predict_hit,
  output logic                predict_taken,
  output logic [PC_WIDTH-1:0] predict_target,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_W-1:0]      fetch_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;

  logic                upd_hit;
  logic                wr_en_d;
  logic [TAG_W-1:0]    tag_d;
  logic [PC_WIDTH-1:0] target_d;
  logic [1:0]          ctr_d;

  // The low two PC bits are ignored; the next INDEX_BITS select the entry and
  // the remaining upper bits form the tag.
  assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag = fetch_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign upd_idx   = update_pc[INDEX_BITS+1:2];
  assign upd_tag   = update_pc[PC_WIDTH-1:INDEX_BITS+2];

  // Same-cycle lookup from stored state only; no bypass from the update port.
  always_comb begin
    predict_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predict_taken  = predict_hit && ctr_q[fetch_idx][1];
    predict_target = predict_hit ? target_q[fetch_idx] : '0;
  end

  // Work out the new contents of the entry addressed by the update port.
  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    wr_en_d  = 1'b0;
    tag_d    = tag_q[upd_idx];
    target_d = target_q[upd_idx];
    ctr_d    = ctr_q[upd_idx];
    if (update_valid) begin
      if (upd_hit) begin
        wr_en_d = 1'b1;
        if (update_taken) begin
          ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          target_d = update_target;
        end else begin
          ctr_d    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (update_taken) begin
        // A taken branch that misses claims the slot, evicting any alias.
        wr_en_d  = 1'b1;
        tag_d    = upd_tag;
        target_d = update_target;
        ctr_d    = 2'b10;
      end
    end
  end

  // Table storage: reset clears every entry, otherwise commit the single write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en_d) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= tag_d;
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vectors with literal expectations
// plus a per-cycle comparison against an abstract table model.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] fetchPc;
  logic        predictHit;
  logic        predictTaken;
  logic [31:0] predictTarget;
  logic        updateValid;
  logic [31:0] updatePc;
  logic        updateTaken;
  logic [31:0] updateTarget;

  int vectors;
  int miscompares;

  // Model state: one slot per line index, owner identified by pc / 256,
  // confidence counted as an integer from 0 to 3.
  bit          mValid  [64];
  int unsigned mOwner  [64];
  int unsigned mTarget [64];
  int          mCtr    [64];

  branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_pc       (fetchPc),
    .predict_hit    (predictHit),
    .predict_taken  (predictTaken),
    .predict_target (predictTarget),
    .update_valid   (updateValid),
    .update_pc      (updatePc),
    .update_taken   (updateTaken),
    .update_target  (updateTarget)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int slotOf(input int unsigned pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int unsigned ownerOf(input int unsigned pc);
    return pc / 256;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 64; i++) begin
      mValid[i]  = 1'b0;
      mOwner[i]  = 0;
      mTarget[i] = 0;
      mCtr[i]    = 1;
    end
  endfunction

  function automatic void modelUpdate(input int unsigned pc, input bit taken,
                                      input int unsigned tgt);
    int s;
    s = slotOf(pc);
    if (mValid[s] && mOwner[s] == ownerOf(pc)) begin
      if (taken) begin
        mCtr[s]    = (mCtr[s] + 1 > 3) ? 3 : mCtr[s] + 1;
        mTarget[s] = tgt;
      end else begin
        mCtr[s] = (mCtr[s] - 1 < 0) ? 0 : mCtr[s] - 1;
      end
    end else if (taken) begin
      mValid[s]  = 1'b1;
      mOwner[s]  = ownerOf(pc);
      mTarget[s] = tgt;
      mCtr[s]    = 2;
    end
  endfunction

  // Model reacts to reset immediately, like the table does.
  always @(posedge reset) modelClear();

  // Model commits resolved branches on the clock edge unless reset is held.
  always @(posedge clk) begin
    if (!reset && updateValid) modelUpdate(updatePc, updateTaken, updateTarget);
  end

  // Every falling edge, check all outputs against the model.
  always @(negedge clk) begin
    bit          eHit;
    bit          eTaken;
    int unsigned eTarget;
    int          s;
    s       = slotOf(fetchPc);
    eHit    = mValid[s] && mOwner[s] == ownerOf(fetchPc);
    eTaken  = eHit && mCtr[s] >= 2;
    eTarget = eHit ? mTarget[s] : 0;
    vectors += 3;
    if (predictHit !== eHit) begin
      miscompares++;
      $display("[TB] FAIL model_hit pc=%h got=%b want=%b t=%0t", fetchPc, predictHit, eHit, $time);
    end
    if (predictTaken !== eTaken) begin
      miscompares++;
      $display("[TB] FAIL model_taken pc=%h got=%b want=%b t=%0t", fetchPc, predictTaken, eTaken, $time);
    end
    if (predictTarget !== eTarget) begin
      miscompares++;
      $display("[TB] FAIL model_target pc=%h got=%h want=%h t=%0t", fetchPc, predictTarget, eTarget, $time);
    end
  end

  // Drive one cycle of inputs shortly after a rising edge.
  task automatic applyStimulus(input logic [31:0] fpc, input logic uv,
                               input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt);
    @(posedge clk);
    #2;
    fetchPc      = fpc;
    updateValid  = uv;
    updatePc     = upc;
    updateTaken  = ut;
    updateTarget = utgt;
  endtask

  // Literal expectation check on the current outputs.
  task automatic checkOutput(input string name, input logic eHit,
                             input logic eTaken, input logic [31:0] eTarget);
    vectors++;
    if (predictHit !== eHit || predictTaken !== eTaken || predictTarget !== eTarget) begin
      miscompares++;
      $display("[TB] FAIL %s got hit=%b taken=%b target=%h want hit=%b taken=%b target=%h",
               name, predictHit, predictTaken, predictTarget, eHit, eTaken, eTarget);
    end
  endtask

  // Idle cycle fetching pc, then check at the following falling edge.
  task automatic fetchCheck(input string name, input logic [31:0] pc, input logic eHit,
                            input logic eTaken, input logic [31:0] eTarget);
    applyStimulus(pc, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput(name, eHit, eTaken, eTarget);
  endtask

  // One resolved branch followed by a check of the same pc on the next cycle.
  task automatic updateCheck(input string name, input logic [31:0] pc, input logic taken,
                             input logic [31:0] tgt, input logic eHit,
                             input logic eTaken, input logic [31:0] eTarget);
    applyStimulus(pc, 1'b1, pc, taken, tgt);
    fetchCheck(name, pc, eHit, eTaken, eTarget);
  endtask

  // Directed sequence.
  initial begin
    vectors      = 0;
    miscompares  = 0;
    modelClear();
    reset        = 1'b1;
    fetchPc      = 32'h0;
    updateValid  = 1'b0;
    updatePc     = 32'h0;
    updateTaken  = 1'b0;
    updateTarget = 32'h0;
    #3;
    checkOutput("in_reset", 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    fetchCheck("after_reset_miss", 32'h0040_0010, 1'b0, 1'b0, 32'h0);

    updateCheck("alloc_hit", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0100);
    updateCheck("nt1_ctr01", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0040_0100);
    updateCheck("nt2_ctr00", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0040_0100);
    updateCheck("nt3_sat00", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0040_0100);
    updateCheck("t1_ctr01",  32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 1'b0, 32'h0040_0100);
    updateCheck("t2_ctr10",  32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0100);
    updateCheck("t3_ctr11",  32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0100);
    updateCheck("t4_sat11_newtgt", 32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 1'b1, 32'h0040_0200);
    updateCheck("nt_ctr10_keeptgt", 32'h0040_0010, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 32'h0040_0200);
    updateCheck("nt_ctr01", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0040_0200);

    // Alias: same index, different tag evicts the old owner.
    updateCheck("alias_new_hit", 32'h0041_0010, 1'b1, 32'h0041_0500, 1'b1, 1'b1, 32'h0041_0500);
    fetchCheck("alias_old_miss", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    updateCheck("alias_ctr01", 32'h0041_0010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0041_0500);

    // Not-taken on an unseen pc must not allocate.
    updateCheck("nt_no_alloc", 32'h0050_0300, 1'b0, 32'h0050_0400, 1'b0, 1'b0, 32'h0);

    // Top index with the two low pc bits differing between update and fetch.
    applyStimulus(32'h0040_00FC, 1'b1, 32'h0040_00FE, 1'b1, 32'h0040_0ABC);
    fetchCheck("idx63_lowbits", 32'h0040_00FD, 1'b1, 1'b1, 32'h0040_0ABC);
    fetchCheck("idx0_untouched", 32'h0040_0000, 1'b0, 1'b0, 32'h0);

    // Same-cycle read and write of one index: old contents this cycle.
    applyStimulus(32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0777);
    @(negedge clk);
    #1;
    checkOutput("same_cycle_old", 1'b0, 1'b0, 32'h0);
    fetchCheck("same_cycle_next", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0777);

    // Asynchronous reset between edges with an allocation pending.
    updateCheck("pre_reset_alloc", 32'h0060_0040, 1'b1, 32'h0060_0900, 1'b1, 1'b1, 32'h0060_0900);
    applyStimulus(32'h0060_0040, 1'b1, 32'h0070_0080, 1'b1, 32'h0070_0999);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_now", 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    reset       = 1'b0;
    updateValid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_reset_e", 1'b0, 1'b0, 32'h0);
    fetchCheck("post_reset_lost", 32'h0070_0080, 1'b0, 1'b0, 32'h0);
    fetchCheck("post_reset_d",    32'h0040_0020, 1'b0, 1'b0, 32'h0);
    fetchCheck("post_reset_b",    32'h0041_0010, 1'b0, 1'b0, 32'h0);

    // Relearn after reset to show the table is writable again.
    updateCheck("relearn", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0100);

    // Short pseudo-random tail checked only by the model.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] pc;
      pc = {8'h00, 4'h4, 2'b00, 6'($urandom_range(0, 3)), 4'h0, 6'($urandom_range(0, 7)), 2'b00};
      applyStimulus(pc, 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), $urandom);
    end
    applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
